// File: rtl/sst_pkg.sv
// Shared types and constants for the save-state sequencer.
// Optional checksum support is selected with SST_CHECKSUM_EN.
package sst_pkg;

  localparam int unsigned SST_IDX_ADDR = 127;

  typedef logic [7:0] sst_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_SET,
    RD_OUT,
    LD_IN,
    LD_WR,
    CK_OUT,
    CK_IN,
    FIN
  } sst_state_t;

endpackage

// File: rtl/sst_cksum.sv
// Running mod-256 byte sum for the save-state stream.
// Instantiated only when SST_CHECKSUM_EN is defined.
module sst_cksum
  import sst_pkg::*;
(
  input  logic      clk,
  input  logic      rst_i,
  input  logic      clr_i,
  input  logic      acc_i,
  input  sst_byte_t byte_i,
  output sst_byte_t sum_o
);

  sst_byte_t sum_q;

  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      sum_q <= '0;
    end else if (acc_i) begin
      sum_q <= sum_q + byte_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/sst_sequencer.sv
// Save-state sequencer: walks the mapper register map to/from the host.
// SST_CHECKSUM_EN adds a trailing checksum byte on save and load.
module sst_sequencer
  import sst_pkg::*;
#(
  parameter int unsigned LAST_ADDR = SST_IDX_ADDR
) (
  input  logic       clk,
  input  logic       map_rst,
  input  logic       start_save,
  input  logic       start_load,
  input  logic       m3,
  input  logic [7:0] sst_di,
  output logic [7:0] sst_addr,
  output logic [7:0] sst_dato,
  output logic       sst_we_reg,
  output logic       act_mc,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       busy,
  output logic       done,
  output logic       cks_err
);

  localparam sst_byte_t LAST    = sst_byte_t'(LAST_ADDR);
  localparam sst_byte_t LAST_LD = sst_byte_t'(LAST_ADDR - 1);

  sst_state_t state_q, state_d;
  sst_byte_t  addr_q, addr_d;
  sst_byte_t  dato_q, dato_d;
  sst_byte_t  txd_q, txd_d;

`ifdef SST_CHECKSUM_EN
  logic      err_q, err_d;
  logic      ck_clr, ck_acc;
  sst_byte_t ck_byte, ck_sum;

  sst_cksum u_cksum (
    .clk   (clk),
    .rst_i (map_rst),
    .clr_i (ck_clr),
    .acc_i (ck_acc),
    .byte_i(ck_byte),
    .sum_o (ck_sum)
  );

  assign ck_byte = (state_q == LD_IN) ? rx_data : sst_di;
  assign cks_err = err_q;
`else
  assign cks_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dato_d  = dato_q;
    txd_d   = txd_q;
`ifdef SST_CHECKSUM_EN
    err_d   = err_q;
    ck_clr  = 1'b0;
    ck_acc  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_save || start_load) begin
          state_d = start_save ? RD_SET : LD_IN;
          addr_d  = '0;
`ifdef SST_CHECKSUM_EN
          err_d   = 1'b0;
          ck_clr  = 1'b1;
`endif
        end
      end
      RD_SET: begin
        txd_d   = sst_di;
        state_d = RD_OUT;
`ifdef SST_CHECKSUM_EN
        ck_acc  = 1'b1;
`endif
      end
      RD_OUT: begin
        if (tx_ready) begin
          if (addr_q == LAST) begin
`ifdef SST_CHECKSUM_EN
            txd_d   = 8'h00 - ck_sum;
            state_d = CK_OUT;
`else
            state_d = FIN;
`endif
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = RD_SET;
          end
        end
      end
      LD_IN: begin
        if (rx_valid) begin
          dato_d  = rx_data;
          state_d = LD_WR;
`ifdef SST_CHECKSUM_EN
          ck_acc  = 1'b1;
`endif
        end
      end
      LD_WR: begin
        // the index register at LAST_ADDR is read-only, so stop short of it
        if (m3) begin
          if (addr_q == LAST_LD) begin
`ifdef SST_CHECKSUM_EN
            state_d = CK_IN;
`else
            state_d = FIN;
`endif
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = LD_IN;
          end
        end
      end
`ifdef SST_CHECKSUM_EN
      CK_OUT: begin
        if (tx_ready) state_d = FIN;
      end
      CK_IN: begin
        if (rx_valid) begin
          err_d   = (ck_sum + rx_data) != 8'h00;
          state_d = FIN;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (map_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dato_q  <= '0;
      txd_q   <= '0;
`ifdef SST_CHECKSUM_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dato_q  <= dato_d;
      txd_q   <= txd_d;
`ifdef SST_CHECKSUM_EN
      err_q   <= err_d;
`endif
    end
  end

  assign sst_addr   = addr_q;
  assign sst_dato   = dato_q;
  assign tx_data    = txd_q;
  assign act_mc     = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign sst_we_reg = (state_q == LD_WR);
  assign tx_valid   = (state_q == RD_OUT) || (state_q == CK_OUT);
  assign rx_ready   = (state_q == LD_IN) || (state_q == CK_IN);

endmodule
